fetch_unit: RTL

Parametrised instruction-fetch front end: owns the PC, issues sequential word reads to the instruction BRAM, and buffers returned instructions with their PCs in a prefetch queue. Presents instructions to decode over a valid/ready handshake. Accepts a redirect, for taken branches and jumps, that flushes all queued and in-flight fetches. Replaces the state-driven single-word fetch stage and sits between instruction memory and decode.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch front
//               end: data width, default reset PC, canonical NOP encoding and
//               the prefetch-queue entry (instruction plus its PC).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = '0;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch queue of fetch_entry_t, DEPTH entries.
//               Flush empties the queue and takes priority over push.
//               The head entry is read straight from storage, so it depends
//               only on registered state.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               push/push_data - write one entry
//               pop            - remove head (ignored when empty)
//               flush          - discard all entries
//               count          - number of queued entries
//               head           - oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !flush && !rst;
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the PC, issues sequential
//               word reads to the instruction BRAM under a credit rule
//               (queued + in-flight < DEPTH), tracks in-flight reads in a
//               MEM_LAT-stage pipe, and buffers returned words with their PCs
//               in a prefetch queue presented to decode over valid/ready.
//               A redirect flushes queued and in-flight fetches.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               imem_en/imem_addr        - BRAM read strobe / word address
//               imem_rdata               - BRAM data, MEM_LAT cycles after en
//               redirect/redirect_pc     - flush and restart at new PC
//               out_valid/out_ready      - decode handshake
//               out_instr/out_pc         - head entry (0 when not valid)
//               perf_fetched/perf_bubble - present only with FETCH_PERF_EN
// Config      : FETCH_PERF_EN - adds handshake and bubble counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              ADDR_W   = 14,
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 1,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubble,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [XLEN-1:0]   out_pc
);

    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  r_pc;
    logic [MEM_LAT-1:0] r_pipe_vld;
    logic [XLEN-1:0]  r_pipe_pc [MEM_LAT];

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_inflight;
    logic [OCC_W-1:0] w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;
    logic [1:0]       w_unused_pc_lsbs;

    // Word alignment is forced on redirect; the low bits carry no meaning.
    assign w_unused_pc_lsbs = redirect_pc[1:0];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
        end
    end

    // Credits use registered occupancy only, so a pop frees its slot for
    // issue one cycle later and a push can never find the queue full.
    assign w_occupancy = {1'b0, w_count} + {1'b0, w_inflight};
    assign w_issue     = !rst && !redirect && (w_occupancy < OCC_W'(DEPTH));

    assign imem_en   = w_issue;
    assign imem_addr = r_pc[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_issue) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // Clearing the valid bits on redirect drops stale reads on arrival.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_pc[0] <= r_pc;
        for (int i = 1; i < MEM_LAT; i++) begin
            r_pipe_pc[i] <= r_pipe_pc[i-1];
        end
    end

    assign w_push             = r_pipe_vld[MEM_LAT-1];
    assign w_push_entry.instr = imem_rdata;
    assign w_push_entry.pc    = r_pipe_pc[MEM_LAT-1];
    assign w_pop              = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect),
        .count     (w_count),
        .head      (w_head)
    );

    assign out_valid = (w_count != '0);
    assign out_instr = out_valid ? w_head.instr : '0;
    assign out_pc    = out_valid ? w_head.pc : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubble;

    // Redirect does not clear these; a handshake in a redirect cycle still
    // counts as delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubble  <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (out_ready && !out_valid) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubble  = r_perf_bubble;
`endif

endmodule
`default_nettype wire
